// File: rtl/wb_burst_mem_ctrl.sv
// rtl/wb_burst_mem_ctrl.sv - Wishbone B4 slave front-end for a single-port one-cycle-latency RAM
// Decodes classic and incrementing bursts; prefetches the next line so bursts run one beat per clock.
module wb_burst_mem_ctrl #(
  parameter int              DW           = 32,
  parameter int              AW           = 32,
  parameter int              MEM_NUM_LINE = 65536,
  parameter logic [AW-1:0]   BASE_ADR     = '0,
  localparam int             LW           = $clog2(MEM_NUM_LINE),
  localparam int             SW           = DW / 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          wb_cyc_i,
  input  logic          wb_stb_i,
  input  logic          wb_we_i,
  input  logic [AW-1:0] wb_adr_i,
  input  logic [DW-1:0] wb_dat_i,
  input  logic [SW-1:0] wb_sel_i,
  input  logic [2:0]    wb_cti_i,
  input  logic [1:0]    wb_bte_i,
  output logic [DW-1:0] wb_dat_o,
  output logic          wb_ack_o,
  output logic          wb_err_o,
  output logic          ram_en_o,
  output logic [SW-1:0] ram_we_o,
  output logic [LW-1:0] ram_adr_o,
  output logic [DW-1:0] ram_dat_o,
  input  logic [DW-1:0] ram_dat_i
);

  localparam int       BW      = $clog2(SW);
  localparam bit [2:0] CTI_INC = 3'b010;
  localparam bit [2:0] CTI_EOB = 3'b111;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLASSIC = 3'd1,
    BURST   = 3'd2,
    STALL   = 3'd3,
    ERR     = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [LW-1:0] adr_q, adr_d;
  logic          ack_q, ack_d;
  logic          err_q, err_d;

  logic [AW-1:0] req_off;
  logic [AW-1:0] req_word;
  logic [LW-1:0] req_idx;
  logic          req_oor;

  logic [LW-1:0] adr_inc;
  logic [LW-1:0] adr_nxt;
  logic          nxt_oor;

  logic          ram_en;
  logic [SW-1:0] ram_we;
  logic [LW-1:0] ram_adr;
  logic [DW-1:0] ram_wdat;

  // Anything below BASE_ADR wraps to a huge word index and is caught as out of range.
  assign req_off  = wb_adr_i - BASE_ADR;
  assign req_word = req_off >> BW;
  assign req_idx  = req_word[LW-1:0];
  assign req_oor  = |req_word[AW-1:LW];

  // Wrapping bursts only advance the low index bits, so they can never leave the RAM.
  always_comb begin
    adr_inc = adr_q + LW'(1);
    adr_nxt = adr_q;
    nxt_oor = 1'b0;
    case (wb_bte_i)
      2'b00: begin
        adr_nxt = adr_inc;
        nxt_oor = (adr_q == {LW{1'b1}});
      end
      2'b01:   adr_nxt[1:0] = adr_inc[1:0];
      2'b10:   adr_nxt[2:0] = adr_inc[2:0];
      default: adr_nxt[3:0] = adr_inc[3:0];
    endcase
  end

  always_comb begin
    state_d  = state_q;
    adr_d    = adr_q;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    ram_en   = 1'b0;
    ram_we   = '0;
    ram_adr  = '0;
    ram_wdat = '0;
    if (!wb_cyc_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (wb_stb_i) begin
            if (req_oor) begin
              err_d   = 1'b1;
              state_d = ERR;
            end else begin
              adr_d   = req_idx;
              ack_d   = 1'b1;
              state_d = (wb_cti_i == CTI_INC) ? BURST : CLASSIC;
              if (!wb_we_i) begin
                ram_en  = 1'b1;
                ram_adr = req_idx;
              end
            end
          end
        end
        CLASSIC: begin
          state_d = IDLE;
          if (wb_stb_i && wb_we_i) begin
            ram_en   = 1'b1;
            ram_we   = wb_sel_i;
            ram_adr  = adr_q;
            ram_wdat = wb_dat_i;
          end
        end
        BURST: begin
          if (wb_stb_i) begin
            if (wb_we_i) begin
              ram_en   = 1'b1;
              ram_we   = wb_sel_i;
              ram_adr  = adr_q;
              ram_wdat = wb_dat_i;
            end
            if (wb_cti_i == CTI_EOB) begin
              state_d = IDLE;
            end else if (nxt_oor) begin
              err_d   = 1'b1;
              state_d = ERR;
            end else begin
              adr_d = adr_nxt;
              ack_d = 1'b1;
              if (!wb_we_i) begin
                ram_en  = 1'b1;
                ram_adr = adr_nxt;
              end
            end
          end else begin
            state_d = STALL;
          end
        end
        STALL: begin
          // The prefetched word was not consumed; fetch it again so no beat is lost.
          if (wb_stb_i) begin
            ack_d   = 1'b1;
            state_d = BURST;
            if (!wb_we_i) begin
              ram_en  = 1'b1;
              ram_adr = adr_q;
            end
          end
        end
        ERR: begin
          if (wb_stb_i) state_d = IDLE;
          else          err_d   = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      adr_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  // RAM strobes are blanked while reset is held so a reset mid-burst cannot write.
  assign ram_en_o  = ram_en & ~rst_i;
  assign ram_we_o  = ram_we & {SW{~rst_i}};
  assign ram_adr_o = ram_adr & {LW{~rst_i}};
  assign ram_dat_o = ram_wdat & {DW{~rst_i}};

  assign wb_ack_o = ack_q & wb_cyc_i & wb_stb_i;
  assign wb_err_o = err_q & wb_cyc_i & wb_stb_i;
  assign wb_dat_o = wb_ack_o ? ram_dat_i : '0;

endmodule

// File: tb/tb_wb_burst_mem_ctrl.sv
// tb/tb_wb_burst_mem_ctrl.sv - scoreboard bench for wb_burst_mem_ctrl
// Directed bus cycles push expected responses; a negedge monitor pops and compares each ack/err.
module tb_wb_burst_mem_ctrl;

  logic        clk_i, rst_i;
  logic        wb_cyc_i, wb_stb_i, wb_we_i;
  logic [31:0] wb_adr_i, wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic [2:0]  wb_cti_i;
  logic [1:0]  wb_bte_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o, wb_err_o;
  logic        ram_en_o;
  logic [3:0]  ram_we_o;
  logic [15:0] ram_adr_o;
  logic [31:0] ram_dat_o;
  logic [31:0] ram_dat_i;

  wb_burst_mem_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
    .wb_cti_i(wb_cti_i), .wb_bte_i(wb_bte_i),
    .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
    .ram_en_o(ram_en_o), .ram_we_o(ram_we_o), .ram_adr_o(ram_adr_o),
    .ram_dat_o(ram_dat_o), .ram_dat_i(ram_dat_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    string       tag;
    bit          is_err;
    bit          chk_dat;
    logic [31:0] dat;
  } exp_t;

  typedef struct packed {
    logic [3:0]  we;
    logic [15:0] adr;
    logic [31:0] dat;
  } log_t;

  exp_t        exp_q[$];
  exp_t        e_cur;
  log_t        ram_log[$];
  logic [31:0] mem [0:65535];
  int          n_chk  = 0;
  int          n_fail = 0;
  int          n_we   = 0;
  int          lat;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void exp_rsp(input string tag, input bit is_err, input bit chk_dat, input logic [31:0] d);
    exp_t e;
    e.tag = tag; e.is_err = is_err; e.chk_dat = chk_dat; e.dat = d;
    exp_q.push_back(e);
  endfunction

  function automatic void chk_log(input string tag, input int i, input logic [3:0] we, input logic [15:0] adr);
    if (i < ram_log.size()) chk(tag, 64'({ram_log[i].we, ram_log[i].adr}), 64'({we, adr}));
    else chk({tag, "_missing"}, 64'(ram_log.size()), 64'(i + 1));
  endfunction

  // RAM model: one-cycle read latency, byte-lane writes.
  always @(posedge clk_i) begin
    if (ram_en_o) begin
      for (int i = 0; i < 4; i++)
        if (ram_we_o[i]) mem[ram_adr_o][8*i +: 8] <= ram_dat_o[8*i +: 8];
      ram_dat_i <= mem[ram_adr_o];
    end
  end

  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (ram_en_o) ram_log.push_back({ram_we_o, ram_adr_o, ram_dat_o});
      if (ram_we_o != 4'h0) n_we++;
      if (wb_ack_o || wb_err_o) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", 64'({wb_ack_o, wb_err_o}), 64'd0);
        end else begin
          e_cur = exp_q.pop_front();
          chk({e_cur.tag, "_ack"}, 64'(wb_ack_o), 64'(!e_cur.is_err));
          chk({e_cur.tag, "_err"}, 64'(wb_err_o), 64'(e_cur.is_err));
          if (e_cur.chk_dat) chk({e_cur.tag, "_dat"}, 64'(wb_dat_o), 64'(e_cur.dat));
        end
      end
    end
  end

  task automatic bus_idle();
    wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0; wb_adr_i = 0;
    wb_dat_i = 0; wb_sel_i = 0; wb_cti_i = 0; wb_bte_i = 0;
    @(posedge clk_i); #1;
  endtask

  task automatic wait_rsp(input string tag, output int l);
    l = 0;
    do begin
      @(negedge clk_i);
      l++;
    end while (!(wb_ack_o || wb_err_o) && l < 16);
    if (!(wb_ack_o || wb_err_o)) begin
      n_chk++; n_fail++;
      $display("FAIL %s_timeout: got no response expected ack or err", tag);
    end
  endtask

  task automatic classic(input string tag, input logic [31:0] a, input logic we,
                         input logic [31:0] d, input logic [3:0] s);
    int l;
    wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = we; wb_adr_i = a;
    wb_dat_i = d; wb_sel_i = s; wb_cti_i = 3'b000; wb_bte_i = 2'b00;
    wait_rsp(tag, l);
    chk({tag, "_lat"}, 64'(l), 64'd2);
    @(posedge clk_i); #1;
    bus_idle();
  endtask

  task automatic burst(input string tag, input logic [31:0] a, input logic [1:0] bte, input logic we,
                       input int nb, input bit eob, input int stall_at, input int stall_len);
    int l;
    bit last;
    wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = we; wb_adr_i = a; wb_bte_i = bte;
    wb_sel_i = 4'hF; wb_dat_i = 32'h1111_0000;
    wb_cti_i = (nb == 1 && eob) ? 3'b111 : 3'b010;
    for (int b = 0; b < nb; b++) begin
      wait_rsp(tag, l);
      chk({tag, "_lat"}, 64'(l), (b == 0 || b == stall_at + 1) ? 64'd2 : 64'd1);
      last = wb_err_o || !wb_ack_o || (b == nb - 1);
      @(posedge clk_i); #1;
      if (last) break;
      wb_dat_i = 32'h1111_0000 + 32'(b + 1);
      wb_cti_i = (b + 1 == nb - 1 && eob) ? 3'b111 : 3'b010;
      if (b == stall_at) begin
        wb_stb_i = 0;
        repeat (stall_len) @(posedge clk_i);
        #1;
        wb_stb_i = 1;
      end
    end
    bus_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 32'hC000_0000 | 32'(i);
    mem[16'h0040] = 32'hDEAD_BEEF;
    ram_dat_i = 0;
    rst_i = 1;
    wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0; wb_adr_i = 0;
    wb_dat_i = 0; wb_sel_i = 0; wb_cti_i = 0; wb_bte_i = 0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_ctl", 64'({wb_ack_o, wb_err_o, ram_en_o, ram_we_o, ram_adr_o}), 64'd0);
    chk("rst_dat", 64'({wb_dat_o, ram_dat_o}), 64'd0);
    @(posedge clk_i); #1;
    rst_i = 0;
    @(posedge clk_i); #1;

    // Classic read held for two back-to-back cycles: one wait state each, ack drops between.
    ram_log.delete();
    exp_rsp("crd0", 0, 1, 32'hDEAD_BEEF);
    exp_rsp("crd1", 0, 1, 32'hDEAD_BEEF);
    wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 0; wb_adr_i = 32'h100; wb_cti_i = 3'b000;
    wait_rsp("crd0", lat);
    chk("crd0_lat", 64'(lat), 64'd2);
    @(posedge clk_i); #1;
    @(negedge clk_i);
    chk("crd_gap_ack", 64'(wb_ack_o), 64'd0);
    wait_rsp("crd1", lat);
    chk("crd1_lat", 64'(lat), 64'd1);
    @(posedge clk_i); #1;
    bus_idle();
    chk("crd_log_n", 64'(ram_log.size()), 64'd2);
    chk_log("crd_log0", 0, 4'h0, 16'h0040);

    // Classic partial write: exactly one RAM write on the ack cycle.
    ram_log.delete();
    exp_rsp("cwr", 0, 0, 32'h0);
    classic("cwr", 32'h104, 1'b1, 32'h1234_5678, 4'b0011);
    chk("cwr_log_n", 64'(ram_log.size()), 64'd1);
    chk_log("cwr_log0", 0, 4'b0011, 16'h0041);
    if (ram_log.size() > 0) chk("cwr_log_dat", 64'(ram_log[0].dat), 64'h1234_5678);

    // WRAP_4 from 0x108: words 2,3,0,1 of the block at line 0x40.
    ram_log.delete();
    exp_rsp("w4_0", 0, 1, 32'hC000_0042);
    exp_rsp("w4_1", 0, 1, 32'hC000_0043);
    exp_rsp("w4_2", 0, 1, 32'hDEAD_BEEF);
    exp_rsp("w4_3", 0, 1, 32'hC000_5678);
    burst("w4", 32'h108, 2'b01, 1'b0, 4, 1'b1, -9, 0);
    chk("w4_state", 64'(dut.state_q), 64'd0);
    chk("w4_log_n", 64'(ram_log.size()), 64'd4);
    chk_log("w4_log2", 2, 4'h0, 16'h0040);
    chk_log("w4_log3", 3, 4'h0, 16'h0041);

    // WRAP_8 from line 0x47 wraps to 0x40.
    exp_rsp("w8_0", 0, 1, 32'hC000_0047);
    exp_rsp("w8_1", 0, 1, 32'hDEAD_BEEF);
    exp_rsp("w8_2", 0, 1, 32'hC000_5678);
    burst("w8", 32'h11C, 2'b10, 1'b0, 3, 1'b1, -9, 0);

    // LINEAR read with strobe dropped for two cycles after the first beat.
    ram_log.delete();
    exp_rsp("stl_0", 0, 1, 32'hC000_0000);
    exp_rsp("stl_1", 0, 1, 32'hC000_0001);
    exp_rsp("stl_2", 0, 1, 32'hC000_0002);
    exp_rsp("stl_3", 0, 1, 32'hC000_0003);
    burst("stl", 32'h0, 2'b00, 1'b0, 4, 1'b1, 0, 2);
    chk("stl_log_n", 64'(ram_log.size()), 64'd5);
    chk_log("stl_log2", 2, 4'h0, 16'h0001);

    // Out of range: one err beat per access, RAM untouched.
    ram_log.delete();
    exp_rsp("oor0", 1, 0, 32'h0);
    exp_rsp("oor1", 1, 0, 32'h0);
    wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 0; wb_adr_i = 32'h0004_0000; wb_cti_i = 3'b000;
    wait_rsp("oor0", lat);
    chk("oor0_lat", 64'(lat), 64'd2);
    @(posedge clk_i); #1;
    @(negedge clk_i);
    chk("oor_gap_err", 64'(wb_err_o), 64'd0);
    wait_rsp("oor1", lat);
    @(posedge clk_i); #1;
    bus_idle();
    chk("oor_log_n", 64'(ram_log.size()), 64'd0);

    // LINEAR burst running off the top of RAM.
    exp_rsp("top_0", 0, 1, 32'hC000_FFFE);
    exp_rsp("top_1", 0, 1, 32'hC000_FFFF);
    exp_rsp("top_2", 1, 0, 32'h0);
    burst("top", 32'h0003_FFF8, 2'b00, 1'b0, 4, 1'b1, -9, 0);

    // LINEAR write burst, read back below.
    ram_log.delete();
    exp_rsp("bwr_0", 0, 0, 32'h0);
    exp_rsp("bwr_1", 0, 0, 32'h0);
    burst("bwr", 32'h180, 2'b00, 1'b1, 2, 1'b1, -9, 0);
    chk("bwr_log_n", 64'(ram_log.size()), 64'd2);
    chk_log("bwr_log1", 1, 4'hF, 16'h0061);
    exp_rsp("rb0", 0, 1, 32'h1111_0000);
    classic("rb0", 32'h180, 1'b0, 32'h0, 4'hF);
    exp_rsp("rb1", 0, 1, 32'h1111_0001);
    classic("rb1", 32'h184, 1'b0, 32'h0, 4'hF);

    // cyc dropped mid-burst without end-of-burst.
    exp_rsp("cdr_0", 0, 1, 32'hC000_0080);
    exp_rsp("cdr_1", 0, 1, 32'hC000_0081);
    burst("cdr", 32'h200, 2'b00, 1'b0, 2, 1'b0, -9, 0);
    @(negedge clk_i);
    chk("cdr_state", 64'(dut.state_q), 64'd0);
    chk("cdr_ackq", 64'({dut.ack_q, dut.err_q}), 64'd0);
    @(posedge clk_i); #1;

    // Reset pulsed mid-burst with cyc/stb still asserted.
    exp_rsp("rsb_0", 0, 1, 32'hC000_00C0);
    wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 0; wb_adr_i = 32'h300; wb_cti_i = 3'b010; wb_bte_i = 2'b00;
    wait_rsp("rsb_0", lat);
    chk("rsb_lat", 64'(lat), 64'd2);
    @(posedge clk_i); #1;
    rst_i = 1;
    @(negedge clk_i);
    chk("rsb_ctl", 64'({wb_ack_o, wb_err_o, ram_en_o, ram_we_o, ram_adr_o}), 64'd0);
    chk("rsb_dat", 64'({wb_dat_o, ram_dat_o}), 64'd0);
    chk("rsb_state", 64'(dut.state_q), 64'd0);
    wb_cyc_i = 0; wb_stb_i = 0;
    @(posedge clk_i); #1;
    rst_i = 0;
    bus_idle();
    exp_rsp("post", 0, 1, 32'hC000_0043);
    classic("post", 32'h10C, 1'b0, 32'h0, 4'hF);

    repeat (3) @(posedge clk_i);
    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    chk("we_pulses", 64'(n_we), 64'd3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_burst_mem_ctrl.md
Name: wb_burst_mem_ctrl

Overview:
Wishbone B4 slave front-end for slave 0, the on-chip memory, placed between the bus interconnect and a synchronous single-port RAM with one-cycle read latency. It decodes classic and incrementing-burst cycles (CTI/BTE) and generates next word addresses internally, so a burst sustains one beat per clock. Out-of-range accesses terminate with err_o.

Parameters:
DW, 32, data width in bits; the RAM line width equals DW.
AW, 32, Wishbone byte-address width.
MEM_NUM_LINE, 65536, number of RAM lines (256 KB); must be a power of two.
BASE_ADR, 32'h0000_0000, byte address of RAM line 0.

Ports:
clk_i  in  1  system clock
rst_i  in  1  asynchronous active-high reset
wb_cyc_i  in  1  bus cycle valid
wb_stb_i  in  1  strobe
wb_we_i  in  1  1=write
wb_adr_i  in  AW  byte address
wb_dat_i  in  DW  write data
wb_sel_i  in  DW/8  byte lanes
wb_cti_i  in  3  cycle type
wb_bte_i  in  2  burst type
wb_dat_o  out  DW  read data
wb_ack_o  out  1  beat acknowledge
wb_err_o  out  1  bus error
ram_en_o  out  1  RAM access enable
ram_we_o  out  DW/8  RAM byte write enables
ram_adr_o  out  log2(MEM_NUM_LINE)  RAM line index
ram_dat_o  out  DW  RAM write data
ram_dat_i  in  DW  RAM read data, valid the cycle after ram_en_o

Behaviour:
- Clock and reset: one clock, clk_i. rst_i is asynchronous and active-high. Reset forces state IDLE and sets every output and internal register to 0.
- Word index: idx = (wb_adr_i - BASE_ADR) >> log2(DW/8).
  - Out of range if idx >= MEM_NUM_LINE.
  - Low address bits below the word boundary are ignored.
- Gating: wb_ack_o = ack_q & wb_cyc_i & wb_stb_i, and wb_err_o = err_q & wb_cyc_i & wb_stb_i. ack_q and err_q are registered and never high together.
- CTI decode:
  - 010 = incrementing burst.
  - 000, 001, 011–110 are treated as classic, one cycle per strobe.
  - 111 = end-of-burst.
- State IDLE, on cyc&stb:
  - Out of range: err_q=1, go to ERR. No RAM access is issued.
  - Read: ram_en_o=1 at idx, latch adr_q=idx. Go to CLASSIC if cti≠010, else BURST.
  - Write: no RAM access yet. Latch adr_q and go to the same target state.
- Write timing (all states): a write happens only on the acked beat. In that cycle ram_en_o=1, ram_we_o=wb_sel_i, ram_dat_o=wb_dat_i, ram_adr_o=adr_q. ram_we_o is 0 in every other cycle.
- State CLASSIC: ack_q=1 and wb_dat_o=ram_dat_i (reads). Return to IDLE, so there is one wait state per classic cycle and ack is low for at least one cycle between classic cycles.
- State BURST: ack_q=1. For each beat with stb&ack:
  - If wb_cti_i==111, it is the last beat: go to IDLE.
  - Otherwise compute nxt from adr_q and issue ram_en_o at nxt (reads):
    - LINEAR: adr_q+1.
    - WRAP_4: increment bits [1:0] only.
    - WRAP_8: increment bits [2:0] only.
    - WRAP_16: increment bits [3:0] only.
  - If nxt is out of range (LINEAR only, adr_q==MEM_NUM_LINE-1), set err_q for the next beat and go to ERR.
  - wb_adr_i is sampled only at burst start. Later beats use adr_q.
- State STALL (burst, cyc=1 and stb=0): ack_q=0 and adr_q is held. When stb reasserts, re-issue ram_en_o at adr_q and return to BURST next cycle; no beat is skipped or duplicated.
- State ERR: err_q is high for one gated beat, then go to IDLE.
- cyc_i=0 in any state: go to IDLE next cycle, ack_q=err_q=0. A pending prefetch read is discarded and no write occurs.
- Latency:
  - Classic: first ack on cycle N+1 after strobe at cycle N.
  - Burst: first ack N+1, then one beat per cycle.
- Reset mid-burst: immediate IDLE, all outputs 0, no RAM write.

Test Plan:
- Classic read at adr 0x100 with RAM[0x40]=0xDEADBEEF -> ram_en_o with ram_adr_o=0x40 at cycle N; wb_ack_o=1 and wb_dat_o=0xDEADBEEF at N+1; ack low at N+2.
- Classic write at 0x104, dat 0x12345678, sel 4'b0011 -> ram_we_o=4'b0011, ram_adr_o=0x41 on the ack cycle only; no other ram_we_o pulse.
- WRAP_4 burst read from 0x108, 4 beats with cti 010,010,010,111 -> words 2,3,0,1 returned on 4 consecutive ack cycles; IDLE afterwards.
- LINEAR burst read from 0x0, stb dropped for 2 cycles after beat 1 -> ack low during the stall; beats return words 0,1,2,3 in order with none skipped.
- Out-of-range 0x0004_0000 -> wb_err_o for one cycle, ram_en_o never asserted; LINEAR burst from 0x3FFF8 -> acks for words 0xFFFE and 0xFFFF, then err on the third beat.
- cyc_i dropped mid-burst, then rst_i pulsed mid-burst -> ack low next cycle and state IDLE; after reset all outputs are 0 and a following classic read completes normally.
